// File: rtl/bus_fabric.sv
// Address decoder and read-data mux for the picorv32 native memory bus.
// Holds a registered one-hot slave select per transaction, with timeout watchdog and sticky error capture.
module bus_fabric #(
   parameter int                       NUM_SLAVES = 8,
   parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = '0,
   parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = '0,
   parameter int                       TIMEOUT    = 255,
   parameter logic [31:0]              ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mem_valid,
   input  logic [31:0]                mem_addr,
   output logic                       mem_ready,
   output logic [31:0]                mem_rdata,
   output logic [NUM_SLAVES-1:0]      slave_sel,
   input  logic [NUM_SLAVES-1:0]      slave_ready,
   input  logic [32*NUM_SLAVES-1:0]   slave_rdata,
   input  logic                       err_clear,
   output logic                       bus_err,
   output logic                       err_sticky,
   output logic                       err_timeout,
   output logic [31:0]                err_addr
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

   state_t                  state;
   state_t                  next_state;
   logic [CW-1:0]           count;
   logic                    hit;
   logic [NUM_SLAVES-1:0]   hit_onehot;
   logic                    sel_ready;
   logic [31:0]             sel_rdata;
   logic                    timeout_hit;

   // Scan from the top down so the lowest-indexed matching window is left standing.
   always_comb begin
      hit        = 1'b0;
      hit_onehot = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
            hit           = 1'b1;
            hit_onehot    = '0;
            hit_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (slave_sel[i]) begin
            sel_ready = slave_ready[i];
            sel_rdata = slave_rdata[32*i +: 32];
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && (count == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (mem_valid) next_state = hit ? ACTIVE : ERROR;
         ACTIVE: begin
            if (sel_ready)        next_state = IDLE;
            else if (timeout_hit) next_state = ERROR;
            else if (!mem_valid)  next_state = IDLE;
         end
         ERROR:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      bus_err   = 1'b0;
      case (state)
         ACTIVE: begin
            mem_ready = sel_ready;
            mem_rdata = sel_rdata;
         end
         ERROR: begin
            mem_ready = 1'b1;
            mem_rdata = ERR_DATA;
            bus_err   = 1'b1;
         end
         default: ;
      endcase
   end

   // The select is held for the whole transaction; the counter saturates rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slave_sel <= '0;
         count     <= '0;
      end else begin
         if (state == IDLE && next_state == ACTIVE) slave_sel <= hit_onehot;
         else if (next_state != ACTIVE)             slave_sel <= '0;
         if (state != ACTIVE)                 count <= '0;
         else if (count != {CW{1'b1}})        count <= count + 1'b1;
      end
   end

   // A new error beats a simultaneous err_clear; clears are ignored while an error completes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_sticky  <= 1'b0;
         err_timeout <= 1'b0;
         err_addr    <= '0;
      end else if (next_state == ERROR) begin
         if (!err_sticky || err_clear) begin
            err_sticky  <= 1'b1;
            err_timeout <= (state == ACTIVE);
            err_addr    <= mem_addr;
         end
      end else if (err_clear && state != ERROR) begin
         err_sticky  <= 1'b0;
         err_timeout <= 1'b0;
         err_addr    <= '0;
      end
   end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: three slaves with overlapping windows and a short watchdog.
// Behavioural slaves assert ready a programmable number of cycles after being selected.
module tb_bus_fabric;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [2:0]  slave_sel;
   logic [2:0]  slave_ready;
   logic [95:0] slave_rdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
   logic        err_clear = 1'b0;
   logic        bus_err;
   logic        err_sticky;
   logic        err_timeout;
   logic [31:0] err_addr;

   int          test_count = 0;
   int          fail_count = 0;
   int          cnt [3];
   int          delay [3];
   logic [2:0]  extra_ready = '0;

   bus_fabric #(
      .NUM_SLAVES(3),
      .SLAVE_BASE({32'h0001_0000, 32'h0002_0000, 32'h0001_0000}),
      .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_E000, 32'hFFFF_0000}),
      .TIMEOUT(4),
      .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .slave_sel(slave_sel),
      .slave_ready(slave_ready), .slave_rdata(slave_rdata), .err_clear(err_clear),
      .bus_err(bus_err), .err_sticky(err_sticky), .err_timeout(err_timeout),
      .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   // Slave i counts the cycles it has been selected and answers when the count reaches delay[i].
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) cnt[i] <= 0;
      end else begin
         for (int i = 0; i < 3; i++) cnt[i] <= slave_sel[i] ? cnt[i] + 1 : 0;
      end
   end

   always_comb begin
      slave_ready = '0;
      for (int i = 0; i < 3; i++)
         slave_ready[i] = (slave_sel[i] && cnt[i] == delay[i]) || extra_ready[i];
   end

   task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic clr);
      mem_valid = valid;
      mem_addr  = addr;
      err_clear = clr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   int n;
   int sel_cycles;

   initial begin
      delay[0] = 1; delay[1] = 2; delay[2] = 0;

      @(negedge clk);
      checkOutput("rst_sel", 32'(slave_sel), 32'h0);
      checkOutput("rst_ready", 32'(mem_ready), 32'h0);
      checkOutput("rst_rdata", mem_rdata, 32'h0);
      checkOutput("rst_bus_err", 32'(bus_err), 32'h0);
      checkOutput("rst_sticky", 32'(err_sticky), 32'h0);
      checkOutput("rst_timeout", 32'(err_timeout), 32'h0);
      checkOutput("rst_err_addr", err_addr, 32'h0);
      reset = 1'b0;

      // Slave 1 read, ready in the third select cycle.
      @(negedge clk);
      applyStimulus(1'b1, 32'h0002_0004, 1'b0);
      @(negedge clk);
      checkOutput("t1_sel", 32'(slave_sel), 32'h2);
      checkOutput("t1_ready_c1", 32'(mem_ready), 32'h0);
      @(negedge clk);
      checkOutput("t1_ready_c2", 32'(mem_ready), 32'h0);
      @(negedge clk);
      checkOutput("t1_ready_c3", 32'(mem_ready), 32'h1);
      checkOutput("t1_rdata", mem_rdata, 32'hBBBB_0001);
      checkOutput("t1_bus_err", 32'(bus_err), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("t1_sel_done", 32'(slave_sel), 32'h0);
      checkOutput("t1_ready_done", 32'(mem_ready), 32'h0);

      // Unmapped address.
      applyStimulus(1'b1, 32'h4000_0000, 1'b0);
      @(negedge clk);
      checkOutput("t2_ready", 32'(mem_ready), 32'h1);
      checkOutput("t2_rdata", mem_rdata, 32'hDEAD_BEEF);
      checkOutput("t2_bus_err", 32'(bus_err), 32'h1);
      checkOutput("t2_sticky", 32'(err_sticky), 32'h1);
      checkOutput("t2_timeout", 32'(err_timeout), 32'h0);
      checkOutput("t2_err_addr", err_addr, 32'h4000_0000);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("t2_bus_err_pulse", 32'(bus_err), 32'h0);
      checkOutput("t2_ready_done", 32'(mem_ready), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("t2_cleared", 32'(err_sticky), 32'h0);

      // Watchdog: slave 0 never answers.
      delay[0] = 1000;
      applyStimulus(1'b1, 32'h0001_8000, 1'b0);
      n = 0;
      sel_cycles = 0;
      while (!mem_ready && n < 20) begin
         @(negedge clk);
         n++;
         if (slave_sel == 3'b001) sel_cycles++;
      end
      checkOutput("t3_latency", 32'(n), 32'd5);
      checkOutput("t3_active_cycles", 32'(sel_cycles), 32'd4);
      checkOutput("t3_sel", 32'(slave_sel), 32'h0);
      checkOutput("t3_rdata", mem_rdata, 32'hDEAD_BEEF);
      checkOutput("t3_bus_err", 32'(bus_err), 32'h1);
      checkOutput("t3_timeout", 32'(err_timeout), 32'h1);
      checkOutput("t3_err_addr", err_addr, 32'h0001_8000);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b1, 32'h5000_0000, 1'b0);
      @(negedge clk);
      checkOutput("t3_second_bus_err", 32'(bus_err), 32'h1);
      checkOutput("t3_keep_err_addr", err_addr, 32'h0001_8000);
      checkOutput("t3_keep_timeout", 32'(err_timeout), 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);

      // Overlapping windows; stray ready on unselected slaves.
      delay[0] = 1;
      extra_ready = 3'b110;
      @(negedge clk);
      checkOutput("t4_idle_stray", 32'(mem_ready), 32'h0);
      applyStimulus(1'b1, 32'h0001_0010, 1'b0);
      @(negedge clk);
      checkOutput("t4_sel", 32'(slave_sel), 32'h1);
      checkOutput("t4_stray_ready", 32'(mem_ready), 32'h0);
      @(negedge clk);
      checkOutput("t4_ready", 32'(mem_ready), 32'h1);
      checkOutput("t4_rdata", mem_rdata, 32'hAAAA_0000);
      applyStimulus(1'b0, 32'h0, 1'b0);
      extra_ready = '0;
      @(negedge clk);

      // err_clear coinciding with a new error.
      applyStimulus(1'b1, 32'h6000_0000, 1'b1);
      @(negedge clk);
      checkOutput("t5_bus_err", 32'(bus_err), 32'h1);
      checkOutput("t5_sticky", 32'(err_sticky), 32'h1);
      checkOutput("t5_err_addr", err_addr, 32'h6000_0000);
      checkOutput("t5_timeout", 32'(err_timeout), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("t5_sticky_held", 32'(err_sticky), 32'h1);
      checkOutput("t5_addr_held", err_addr, 32'h6000_0000);
      applyStimulus(1'b0, 32'h0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("t5_clr_sticky", 32'(err_sticky), 32'h0);
      checkOutput("t5_clr_timeout", 32'(err_timeout), 32'h0);
      checkOutput("t5_clr_addr", err_addr, 32'h0);

      // Asynchronous reset during ACTIVE.
      delay[1] = 1000;
      applyStimulus(1'b1, 32'h0002_0008, 1'b0);
      @(negedge clk);
      checkOutput("t6_sel_before", 32'(slave_sel), 32'h2);
      #2;
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("t6_async_sel", 32'(slave_sel), 32'h0);
      checkOutput("t6_async_ready", 32'(mem_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      delay[1] = 0;
      applyStimulus(1'b1, 32'h0002_0000, 1'b0);
      @(negedge clk);
      checkOutput("t6_sel_after", 32'(slave_sel), 32'h2);
      checkOutput("t6_ready_after", 32'(mem_ready), 32'h1);
      checkOutput("t6_rdata_after", mem_rdata, 32'hBBBB_0001);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("t6_sel_done", 32'(slave_sel), 32'h0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
